rx_stream_arbiter: RTL and testbench
====================================

Name: rx_stream_arbiter

Overview:
- Packet-aware, N-way round-robin arbiter that merges the per-DSP 36-bit VITA RX streams into one host RX stream.
- Replaces the cascaded chain of 2-input fifo36 muxes, which gives unequal shares when more than two DSPs are present.
- Sits between the per-DSP RX data FIFOs and the combined RX FIFO.
- Grants only at packet boundaries; per-input enable mask and packet counter are accessible over the settings bus.

Parameters:
- NUM_INPUTS, 2, number of input streams (2..8).
- BASE, 0, settings-bus base address.
- IDX_W, 3, width of the grant index; must satisfy 2**IDX_W >= NUM_INPUTS.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of arbitration state.
- set_stb  input  1  settings strobe.
- set_addr  input  8  settings address.
- set_data  input  32  settings data.
- in_data  input  36*NUM_INPUTS  input streams; input k occupies bits [36k+35:36k]; bit 32 = SOF, bit 33 = EOF.
- in_src_rdy  input  NUM_INPUTS  per-input valid.
- in_dst_rdy  output  NUM_INPUTS  per-input ready.
- out_data  output  36  merged stream.
- out_src_rdy  output  1  merged valid.
- out_dst_rdy  input  1  merged ready.
- grant_idx  output  IDX_W  index of the current or last granted input.
- busy  output  1  high while in XFER.
- pkt_count  output  32  packets forwarded since reset or clear (readback word).

Behaviour:
- Transfer rule: a word moves when src_rdy and dst_rdy are both high on a rising clk edge.
- Settings registers:
  - BASE+0, bits [NUM_INPUTS-1:0] = enable mask; reset value all ones; not affected by clear.
  - BASE+1, any write zeroes pkt_count.
- Request vector: req = in_src_rdy & mask.
- State machine, 2 states:
  - IDLE:
    - out_src_rdy = 0; all in_dst_rdy = 0.
    - If req != 0: select the first set bit of req searching upward from last_grant+1, wrapping modulo NUM_INPUTS.
    - Register the selection into grant_idx and last_grant, then go to XFER.
  - XFER:
    - Combinational pass-through: out_data = in_data[grant], out_src_rdy = in_src_rdy[grant], in_dst_rdy[grant] = out_dst_rdy.
    - All other in_dst_rdy = 0.
    - On a transferred word with EOF=1: pkt_count increments (wraps 2^32-1 -> 0), next state IDLE.
- Latency: the cycle after a request is seen in IDLE, the first word is presented. Exactly one idle bubble cycle follows each packet.
- Single-word packets (SOF=1, EOF=1) are forwarded in one XFER cycle.
- SOF is not checked; the block forwards words verbatim.
- Mask change mid-packet: the current packet still completes. The mask affects only the next arbitration.
- Mask = 0: stays in IDLE indefinitely; no input is acknowledged.
- Stall: out_dst_rdy low holds the state; no word is dropped or duplicated.
- Input valid deasserted mid-packet: the arbiter waits in XFER; the grant is not revoked.
- Simultaneous BASE+1 write and EOF transfer: the write wins, and pkt_count = 0.
- Reset (async) outputs and state:
  - state IDLE; last_grant = NUM_INPUTS-1, so input 0 wins first.
  - grant_idx = 0, mask all ones, pkt_count = 0, busy = 0, out_src_rdy = 0, in_dst_rdy = 0.
  - out_data is don't-care but driven 0.
- Clear (sync), including mid-packet:
  - Abandons the packet and goes to IDLE.
  - last_grant = NUM_INPUTS-1, pkt_count = 0.
  - Mask is retained; the upstream remainder is the caller's responsibility (the upstream FIFOs are cleared together with this block).
- Reset during XFER: outputs drop to reset values immediately, without waiting for a clock edge.

Test Plan:
- NUM_INPUTS=4, all inputs hold 3-word packets continuously, out_dst_rdy=1 -> grant order 0,1,2,3,0,...; each packet takes 3 cycles plus 1 bubble; pkt_count=8 after 32 cycles.
- Only input 2 requests, with 1-word packets (SOF|EOF) -> every packet granted to input 2, one word every 2 cycles; in_dst_rdy[0,1,3] stay 0.
- Mask written to 4'b0101 while input 1 is mid-packet -> input 1 packet completes, then grants alternate 2,0,2,0; inputs 1 and 3 are never acknowledged afterwards.
- out_dst_rdy toggled pseudo-randomly during a 10-word packet from input 3 -> out_data sequence identical to the input; exactly 10 transfers; EOF is on word 10 only.
- clear asserted on word 2 of a 5-word packet -> next cycle busy=0, pkt_count=0; next grant goes to the lowest requesting input.
- Async reset pulsed between clock edges during XFER -> out_src_rdy and in_dst_rdy go 0 before the next edge; mask reads all ones afterwards.

Source files
------------

// File: rtl/rx_stream_arbiter_if.sv
// rtl/rx_stream_arbiter_if.sv - stream and settings bundle for rx_stream_arbiter
//
// Groups the settings bus, the NUM_INPUTS packed input streams and the merged
// output stream. Each stream word is 36 bits: [31:0] payload, [32] SOF, [33] EOF.
//   set_stb/set_addr/set_data   settings write strobe, address, data
//   in_data/in_src_rdy          per-input words (input k at [36k+35:36k]) and valid
//   in_dst_rdy                  per-input ready back to the source FIFOs
//   out_data/out_src_rdy        merged word and valid
//   out_dst_rdy                 merged ready from the combined RX FIFO
// master: the environment (FIFOs, settings bus). slave: the arbiter.
interface rx_stream_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  logic                     set_stb;
  logic [7:0]               set_addr;
  logic [31:0]              set_data;
  logic [36*NUM_INPUTS-1:0] in_data;
  logic [NUM_INPUTS-1:0]    in_src_rdy;
  logic [NUM_INPUTS-1:0]    in_dst_rdy;
  logic [35:0]              out_data;
  logic                     out_src_rdy;
  logic                     out_dst_rdy;

  modport master (
    output set_stb, set_addr, set_data, in_data, in_src_rdy, out_dst_rdy,
    input  in_dst_rdy, out_data, out_src_rdy
  );

  modport slave (
    input  set_stb, set_addr, set_data, in_data, in_src_rdy, out_dst_rdy,
    output in_dst_rdy, out_data, out_src_rdy
  );
endinterface

// File: rtl/rx_stream_arbiter.sv
// rtl/rx_stream_arbiter.sv - packet-aware N-way round-robin merge of 36-bit RX streams
//
// Merges NUM_INPUTS VITA RX streams into one, granting only between packets so
// every input gets an equal share. Settings: BASE+0 = enable mask (reset all
// ones, kept across clear), BASE+1 = any write zeroes pkt_count.
//   clk        system clock
//   reset      asynchronous, active-high reset
//   clear      synchronous flush of arbitration state and packet counter
//   bus        rx_stream_arbiter_if.slave (settings, input streams, output stream)
//   grant_idx  index of the current or last granted input
//   busy       high while a packet is being forwarded
//   pkt_count  packets forwarded since reset, clear or counter write
module rx_stream_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int BASE       = 0,
  parameter int IDX_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  rx_stream_arbiter_if.slave  bus,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                busy,
  output logic [31:0]         pkt_count
);
  localparam int SLOTS  = 2 ** IDX_W;
  localparam int WRAP_W = IDX_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  logic [0:0]            state;
  logic [NUM_INPUTS-1:0] mask;
  logic [IDX_W-1:0]      last_grant;

  logic [NUM_INPUTS-1:0] req;
  logic [2*SLOTS-1:0]    req_ext;
  logic [WRAP_W-1:0]     cand;
  logic                  sel_valid;
  logic [IDX_W-1:0]      sel_idx;

  logic [35:0]           words [SLOTS];
  logic [SLOTS-1:0]      src_ext;

  logic xfer;
  logic word_fire;
  logic eof_fire;
  logic mask_wr;
  logic count_wr;
  logic unused_set_bits;

  // Only the low NUM_INPUTS bits of a mask write are meaningful.
  assign unused_set_bits = ^bus.set_data;

  assign req = bus.in_src_rdy & mask;

  // Pad the request and valid vectors so any index the wrap arithmetic or the
  // grant register can produce selects a real bit.
  always_comb begin
    req_ext = '0;
    req_ext[NUM_INPUTS-1:0] = req;
    src_ext = '0;
    src_ext[NUM_INPUTS-1:0] = bus.in_src_rdy;
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_words
    if (g < NUM_INPUTS) begin : g_used
      assign words[g] = bus.in_data[36*g +: 36];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end

  // Round-robin search from last_grant+1 upward, wrapping modulo NUM_INPUTS.
  // Offsets are scanned from farthest to nearest so the nearest hit wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = NUM_INPUTS; i >= 1; i--) begin
      cand = {1'b0, last_grant} + WRAP_W'(i);
      if (cand >= WRAP_W'(NUM_INPUTS)) begin
        cand = cand - WRAP_W'(NUM_INPUTS);
      end
      if (req_ext[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign xfer = (state == S_XFER);
  assign busy = xfer;

  // Pass-through is purely combinational so reset drops it without a clock.
  assign bus.out_data    = xfer ? words[grant_idx] : 36'd0;
  assign bus.out_src_rdy = xfer & src_ext[grant_idx];

  always_comb begin
    bus.in_dst_rdy = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      bus.in_dst_rdy[k] = xfer && (grant_idx == IDX_W'(k)) && bus.out_dst_rdy;
    end
  end

  assign word_fire = bus.out_src_rdy & bus.out_dst_rdy;
  assign eof_fire  = word_fire & bus.out_data[33];
  assign mask_wr   = bus.set_stb && (bus.set_addr == 8'(BASE));
  assign count_wr  = bus.set_stb && (bus.set_addr == 8'(BASE + 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= LAST_IDX;
      grant_idx  <= '0;
      mask       <= '1;
      pkt_count  <= '0;
    end else begin
      if (mask_wr) begin
        mask <= bus.set_data[NUM_INPUTS-1:0];
      end
      if (clear) begin
        state      <= S_IDLE;
        last_grant <= LAST_IDX;
        pkt_count  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sel_valid) begin
              grant_idx  <= sel_idx;
              last_grant <= sel_idx;
              state      <= S_XFER;
            end
          end
          default: begin
            if (eof_fire) begin
              pkt_count <= pkt_count + 32'd1;
              state     <= S_IDLE;
            end
          end
        endcase
        // A counter write issued alongside a final word still leaves zero.
        if (count_wr) begin
          pkt_count <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_stream_arbiter.sv
// tb/tb_rx_stream_arbiter.sv - directed self-checking bench for rx_stream_arbiter
module tb_rx_stream_arbiter;
  localparam int N    = 4;
  localparam int BASE = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [2:0]  grant_idx;
  logic        busy;
  logic [31:0] pkt_count;

  rx_stream_arbiter_if #(.NUM_INPUTS(N)) bus ();

  rx_stream_arbiter #(.NUM_INPUTS(N), .BASE(BASE), .IDX_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .bus(bus.slave),
    .grant_idx(grant_idx),
    .busy(busy),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  bit          src_on   [N];
  int          src_len  [N];
  int          src_widx [N];
  int          src_pnum [N];
  int          src_left [N];
  bit          stall_mode;
  logic [31:0] stall_pat = 32'hB2E59D36;

  logic [35:0] log_data [$];
  int          log_cyc  [$];
  int          ack_cnt  [N];
  int          cyc;

  int vectors;
  int miscompares;

  function automatic logic [35:0] mk_word(int k, int pn, int w, int len);
    logic [35:0] d;
    d        = '0;
    d[33]    = (w == len - 1);
    d[32]    = (w == 0);
    d[31:24] = 8'(k);
    d[23:16] = 8'(pn);
    d[15:0]  = 16'(w);
    return d;
  endfunction

  task automatic drive_sources();
    for (int k = 0; k < N; k++) begin
      bus.in_src_rdy[k]      = src_on[k] && (src_left[k] != 0);
      bus.in_data[36*k +: 36] = mk_word(k, src_pnum[k], src_widx[k], src_len[k]);
    end
  endtask

  task automatic reset_sources();
    for (int k = 0; k < N; k++) begin
      src_on[k]   = 1'b0;
      src_len[k]  = 1;
      src_widx[k] = 0;
      src_pnum[k] = 0;
      src_left[k] = -1;
      ack_cnt[k]  = 0;
    end
    drive_sources();
  endtask

  // Entered and left just after a falling edge; the transfers decided by the
  // stable signals are logged, then the sources advance after the rising edge.
  task automatic cycle();
    logic [N-1:0] adv;
    adv = bus.in_src_rdy & bus.in_dst_rdy;
    if (bus.out_src_rdy && bus.out_dst_rdy) begin
      log_data.push_back(bus.out_data);
      log_cyc.push_back(cyc);
    end
    for (int k = 0; k < N; k++) if (adv[k]) ack_cnt[k]++;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (adv[k]) begin
        src_widx[k]++;
        if (src_widx[k] == src_len[k]) begin
          src_widx[k] = 0;
          src_pnum[k]++;
          if (src_left[k] > 0) src_left[k]--;
        end
      end
    end
    if (stall_mode) bus.out_dst_rdy = stall_pat[cyc % 32];
    drive_sources();
    @(negedge clk);
  endtask

  task automatic start_test();
    reset           = 1'b1;
    clear           = 1'b0;
    bus.set_stb     = 1'b0;
    bus.set_addr    = 8'd0;
    bus.set_data    = 32'd0;
    bus.out_dst_rdy = 1'b1;
    stall_mode      = 1'b0;
    reset_sources();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    log_data.delete();
    log_cyc.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    start_test();
    for (int k = 0; k < N; k++) src_on[k] = 1'b1;
    drive_sources();
    reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (bus.out_src_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_out_src_rdy: got %b want 0", bus.out_src_rdy); end
    vectors++; if (bus.in_dst_rdy !== 4'b0000) begin miscompares++; $display("FAIL reset_in_dst_rdy: got %b want 0000", bus.in_dst_rdy); end
    vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    vectors++; if (grant_idx !== 3'd0) begin miscompares++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
    vectors++; if (bus.out_data !== 36'd0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_after_release: got %b want 0", busy); end
    cycle();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_first_grant_busy: got %b want 1", busy); end
    vectors++; if (grant_idx !== 3'd0) begin miscompares++; $display("FAIL reset_first_grant_idx: got %0d want 0", grant_idx); end
  endtask

  task automatic test_round_robin();
    logic [35:0] exp;
    start_test();
    for (int k = 0; k < N; k++) begin src_on[k] = 1'b1; src_len[k] = 3; end
    drive_sources();
    repeat (32) cycle();
    vectors++; if (pkt_count !== 32'd8) begin miscompares++; $display("FAIL rr_pkt_count: got %0d want 8", pkt_count); end
    vectors++; if (log_data.size() != 24) begin miscompares++; $display("FAIL rr_words: got %0d want 24", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 24; i++) begin
      exp = mk_word((i / 3) % 4, i / 12, i % 3, 3);
      vectors++; if (log_data[i] !== exp) begin miscompares++; $display("FAIL rr_word%0d: got %h want %h", i, log_data[i], exp); end
      vectors++; if (log_cyc[i] != (i / 3) * 4 + (i % 3) + 1) begin miscompares++; $display("FAIL rr_timing%0d: got cycle %0d want %0d", i, log_cyc[i], (i / 3) * 4 + (i % 3) + 1); end
    end
  endtask

  task automatic test_single_word();
    logic [35:0] exp;
    start_test();
    src_on[2]  = 1'b1;
    src_len[2] = 1;
    drive_sources();
    repeat (10) cycle();
    vectors++; if (log_data.size() != 5) begin miscompares++; $display("FAIL sw_words: got %0d want 5", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 5; i++) begin
      exp = mk_word(2, i, 0, 1);
      vectors++; if (log_data[i] !== exp) begin miscompares++; $display("FAIL sw_word%0d: got %h want %h", i, log_data[i], exp); end
      vectors++; if (log_cyc[i] != 2 * i + 1) begin miscompares++; $display("FAIL sw_timing%0d: got cycle %0d want %0d", i, log_cyc[i], 2 * i + 1); end
    end
    vectors++; if (ack_cnt[0] + ack_cnt[1] + ack_cnt[3] != 0) begin miscompares++; $display("FAIL sw_other_acks: got %0d want 0", ack_cnt[0] + ack_cnt[1] + ack_cnt[3]); end
    vectors++; if (pkt_count !== 32'd5) begin miscompares++; $display("FAIL sw_pkt_count: got %0d want 5", pkt_count); end
  endtask

  task automatic test_mask_change();
    int          exp_src [6] = '{0, 1, 2, 0, 2, 0};
    int          seen [N];
    logic [35:0] exp;
    start_test();
    for (int k = 0; k < N; k++) begin src_on[k] = 1'b1; src_len[k] = 3; seen[k] = 0; end
    drive_sources();
    repeat (5) cycle();
    bus.set_stb  = 1'b1;
    bus.set_addr = 8'(BASE);
    bus.set_data = 32'h0000_0005;
    cycle();
    bus.set_stb  = 1'b0;
    repeat (18) cycle();
    vectors++; if (log_data.size() != 18) begin miscompares++; $display("FAIL mask_words: got %0d want 18", log_data.size()); end
    for (int p = 0; p < 6; p++) begin
      for (int w = 0; w < 3; w++) begin
        exp = mk_word(exp_src[p], seen[exp_src[p]], w, 3);
        if (p * 3 + w < log_data.size()) begin
          vectors++; if (log_data[p * 3 + w] !== exp) begin miscompares++; $display("FAIL mask_word%0d: got %h want %h", p * 3 + w, log_data[p * 3 + w], exp); end
        end
      end
      seen[exp_src[p]]++;
    end
    vectors++; if (ack_cnt[1] != 3) begin miscompares++; $display("FAIL mask_in1_acks: got %0d want 3", ack_cnt[1]); end
    vectors++; if (ack_cnt[3] != 0) begin miscompares++; $display("FAIL mask_in3_acks: got %0d want 0", ack_cnt[3]); end
    vectors++; if (pkt_count !== 32'd6) begin miscompares++; $display("FAIL mask_pkt_count: got %0d want 6", pkt_count); end
  endtask

  task automatic test_stall();
    logic [35:0] exp;
    start_test();
    src_on[3]   = 1'b1;
    src_len[3]  = 10;
    src_left[3] = 1;
    stall_mode  = 1'b1;
    bus.out_dst_rdy = 1'b0;
    drive_sources();
    for (int t = 0; t < 100 && log_data.size() < 10; t++) cycle();
    repeat (5) cycle();
    vectors++; if (log_data.size() != 10) begin miscompares++; $display("FAIL stall_words: got %0d want 10", log_data.size()); end
    for (int i = 0; i < log_data.size() && i < 10; i++) begin
      exp = mk_word(3, 0, i, 10);
      vectors++; if (log_data[i] !== exp) begin miscompares++; $display("FAIL stall_word%0d: got %h want %h", i, log_data[i], exp); end
    end
    vectors++; if (ack_cnt[3] != 10) begin miscompares++; $display("FAIL stall_acks: got %0d want 10", ack_cnt[3]); end
    vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL stall_pkt_count: got %0d want 1", pkt_count); end
    vectors++; if (grant_idx !== 3'd3) begin miscompares++; $display("FAIL stall_grant: got %0d want 3", grant_idx); end
  endtask

  task automatic test_clear();
    logic [35:0] exp;
    start_test();
    src_on[1] = 1'b1; src_len[1] = 5;
    src_on[2] = 1'b1; src_len[2] = 5;
    drive_sources();
    repeat (8) cycle();
    vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL clear_pre_count: got %0d want 1", pkt_count); end
    vectors++; if (grant_idx !== 3'd2) begin miscompares++; $display("FAIL clear_pre_grant: got %0d want 2", grant_idx); end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    src_widx[2] = 0;
    drive_sources();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy: got %b want 0", busy); end
    vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("FAIL clear_pkt_count: got %0d want 0", pkt_count); end
    cycle();
    exp = mk_word(1, 1, 0, 5);
    vectors++; if (grant_idx !== 3'd1) begin miscompares++; $display("FAIL clear_next_grant: got %0d want 1", grant_idx); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_next_busy: got %b want 1", busy); end
    vectors++; if (bus.out_data !== exp) begin miscompares++; $display("FAIL clear_next_word: got %h want %h", bus.out_data, exp); end
  endtask

  task automatic test_async_reset();
    logic [35:0] w0;
    logic [35:0] w1;
    start_test();
    src_on[0] = 1'b1; src_len[0] = 5;
    drive_sources();
    repeat (2) cycle();
    vectors++; if (bus.out_src_rdy !== 1'b1) begin miscompares++; $display("FAIL areset_pre_valid: got %b want 1", bus.out_src_rdy); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (bus.out_src_rdy !== 1'b0) begin miscompares++; $display("FAIL areset_out_src_rdy: got %b want 0", bus.out_src_rdy); end
    vectors++; if (bus.in_dst_rdy !== 4'b0000) begin miscompares++; $display("FAIL areset_in_dst_rdy: got %b want 0000", bus.in_dst_rdy); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", busy); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_sources();
    src_on[1] = 1'b1;
    src_on[3] = 1'b1;
    drive_sources();
    cyc = 0;
    log_data.delete();
    log_cyc.delete();
    @(negedge clk);
    repeat (4) cycle();
    vectors++; if (log_data.size() != 2) begin miscompares++; $display("FAIL areset_words: got %0d want 2", log_data.size()); end
    if (log_data.size() >= 2) begin
      w0 = log_data[0];
      w1 = log_data[1];
      vectors++; if (w0 !== mk_word(1, 0, 0, 1)) begin miscompares++; $display("FAIL areset_mask_in1: got %h want %h", w0, mk_word(1, 0, 0, 1)); end
      vectors++; if (w1 !== mk_word(3, 0, 0, 1)) begin miscompares++; $display("FAIL areset_mask_in3: got %h want %h", w1, mk_word(3, 0, 0, 1)); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clear       = 1'b0;
    test_reset();
    test_round_robin();
    test_single_word();
    test_mask_change();
    test_stall();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
